adc0808_scan_ctrl: RTL
======================

Name: adc0808_scan_ctrl

Overview:
Sequencer that drives the ADC0808 control handshake and scans a programmable set of analog channels. It generates the converter clock and the ALE/START/OE strobes, and synchronises EOC. It captures each 8-bit result and presents it with its channel number as a one-cycle valid pulse. It sits directly upstream of binary_to_bcd and the display path, and replaces the fixed single-channel interface.

Parameters:
CLK_DIV, 100, CLK100MHZ cycles per adc_clk half-period (500 kHz at 100 MHz)
SETUP_CYC, 4, cycles addr is stable before ale rises, and between strobe edges
PULSE_CYC, 20, width of the ale and start pulses in cycles (200 ns)
OE_SETTLE, 4, cycles oe is high before data_in is sampled
TIMEOUT_CYC, 20000, maximum cycles spent in either EOC wait state

Ports:
CLK100MHZ  in  1  system clock
reset  in  1  asynchronous, active-low (0 = reset)
scan_en  in  1  1 = run conversions continuously; 0 = stop after the current conversion
ch_mask  in  8  bit i set = channel i included in the scan
eoc  in  1  ADC0808 end-of-conversion; asynchronous to CLK100MHZ
data_in  in  8  ADC0808 tri-state data bus
adc_clk  out  1  ADC0808 clock
ale  out  1  address latch enable
start  out  1  start-conversion pulse
oe  out  1  output enable
addr  out  3  analog channel select
data_out  out  8  last captured result
data_ch  out  3  channel of data_out
data_valid  out  1  one-cycle pulse when a new result is presented
timeout_err  out  1  sticky; set on any EOC timeout; cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. adc_clk, ale, start, oe, addr, data_out, data_ch, data_valid and timeout_err are all 0. The divider is cleared and the eoc synchroniser is cleared to 0.
- adc_clk toggles every CLK_DIV cycles, free-running out of reset, independent of the FSM.
- eoc passes through a 2-flop synchroniser (eoc_s). All FSM decisions use eoc_s.
- A cycle counter is reloaded on every state entry and drives all timed waits.
- IDLE: if scan_en=1 and ch_mask!=0, select the channel and go to ADDR.
  - Channel selection: the lowest set bit of ch_mask at or above cur_ch, wrapping past 7 to 0. cur_ch starts at 0.
  - If ch_mask=0, stay in IDLE.
- ADDR: addr=channel; wait SETUP_CYC, then go to ALE.
- ALE: ale=1 for PULSE_CYC, then go to START.
- START: ale=0; start=1 for PULSE_CYC, then start=0 and go to WAIT_LO.
- WAIT_LO: wait for eoc_s=0, then go to WAIT_HI.
- WAIT_HI: wait for eoc_s=1, then go to READ.
- Timeout in either wait state: after TIMEOUT_CYC cycles, set timeout_err, produce no data_valid, and go to NEXT.
- READ: oe=1; after OE_SETTLE cycles, latch data_in into data_out and addr into data_ch, set oe=0, and go to DONE.
- DONE: data_valid=1 for exactly 1 cycle, then go to NEXT.
- NEXT: cur_ch = selected channel + 1 (mod 8).
  - If scan_en=1 and ch_mask!=0, go to ADDR with the next channel.
  - Otherwise go to IDLE.
- ch_mask and scan_en changes take effect only at IDLE or NEXT. A conversion in progress always completes.
- ale, start and oe are never high simultaneously. addr changes only in ADDR.
- data_out and data_ch hold their values between data_valid pulses.
- Latency from start falling to data_valid: EOC delay + 2 (sync) + OE_SETTLE + 2 cycles.

Optional Feature:
ADC_AVG4_EN
- Defined: each selected channel is converted 4 times back-to-back (ADDR through READ, repeated).
  - Results are summed in a 10-bit accumulator.
  - data_out = sum[9:2], with a single data_valid per 4 conversions.
  - A timeout during any of the 4 conversions discards the accumulation and advances to the next channel.
- Undefined: one conversion per data_valid, as above.

Decomposition:
- Package adc_pkg holds:
  - the FSM state enum (IDLE, ADDR, ALE, START, WAIT_LO, WAIT_HI, READ, DONE, NEXT);
  - ADC_W=8 and CH_W=3;
  - the counter width derived from TIMEOUT_CYC.
- Sub-module adc_clk_gen (CLK_DIV divider producing adc_clk) is natural and reusable. The synchroniser and FSM stay inline.

Test Plan:
- Default parameters, ch_mask=8'h01, scan_en=1; EOC model drops 100 ns after start falls and rises 100 µs later with data_in=8'hA7 -> ale then start pulses of 20 cycles each, addr=0; data_valid pulses once with data_out=8'hA7, data_ch=0; repeats continuously.
- ch_mask=8'b1010_0100 -> addr sequence 2,5,7,2,... with matching data_ch; ale, start and oe never overlap.
- eoc held high forever -> timeout_err=1 after 20000 cycles in WAIT_LO; no data_valid; next channel attempted.
- scan_en dropped mid-conversion on channel 3 -> that conversion completes with one data_valid and data_ch=3; FSM returns to IDLE; strobes stay low.
- reset asserted while oe=1 in READ -> all outputs 0 on the same edge; after release the scan restarts at channel 0.
- ADC_AVG4_EN, channel 1 returning 10, 11, 12, 13 -> a single data_valid with data_out=8'd11.

Source files
------------

// File: rtl/adc0808_scan_ctrl_pkg.sv
// Shared types and helpers for the ADC0808 scan controller.
// Holds the FSM state enum, bus widths and channel selection.
package adc_pkg;

    localparam int ADC_W = 8;
    localparam int CH_W = 3;
    localparam int ACC_W = ADC_W + 2;
    localparam int TIMEOUT_CYC_DEF = 20000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(TIMEOUT_CYC_DEF);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ALE,
        START,
        WAIT_LO,
        WAIT_HI,
        READ,
        DONE,
        NEXT
    } state_t;

    // Lowest set mask bit at or above 'from', wrapping past 7 to 0.
    function automatic logic [CH_W-1:0] next_ch(
        input logic [7:0]      mask,
        input logic [CH_W-1:0] from
    );
        logic [CH_W-1:0] c;
        next_ch = from;
        for (int i = 7; i >= 0; i--) begin
            c = from + CH_W'(i);
            if (mask[c]) next_ch = c;
        end
    endfunction

endpackage

// File: rtl/adc0808_scan_ctrl_if.sv
// Control, ADC pin and result bundle of the scan controller.
// master = controller side, slave = converter/consumer side.
interface adc0808_scan_ctrl_if;
    import adc_pkg::*;

    logic              scan_en;
    logic [7:0]        ch_mask;
    logic              eoc;
    logic [ADC_W-1:0]  data_in;
    logic              adc_clk;
    logic              ale;
    logic              start;
    logic              oe;
    logic [CH_W-1:0]   addr;
    logic [ADC_W-1:0]  data_out;
    logic [CH_W-1:0]   data_ch;
    logic              data_valid;
    logic              timeout_err;

    modport master (
        input  scan_en, ch_mask, eoc, data_in,
        output adc_clk, ale, start, oe, addr,
        output data_out, data_ch, data_valid, timeout_err
    );

    modport slave (
        output scan_en, ch_mask, eoc, data_in,
        input  adc_clk, ale, start, oe, addr,
        input  data_out, data_ch, data_valid, timeout_err
    );

endinterface

// File: rtl/adc0808_scan_ctrl_clk_gen.sv
// Free-running divider: clk_out toggles every CLK_DIV input cycles.
module adc_clk_gen #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out
);

    localparam int W = $clog2(CLK_DIV + 1);
    localparam logic [W-1:0] LIM = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_q, clk_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        clk_d = clk_q;
        if (cnt_q == LIM) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: rtl/adc0808_scan_ctrl.sv
// ADC0808 handshake sequencer scanning a masked channel set.
// Define ADC_AVG4_EN to average four conversions per result.
module adc0808_scan_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV     = 100,
    parameter int SETUP_CYC   = 4,
    parameter int PULSE_CYC   = 20,
    parameter int OE_SETTLE   = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input logic CLK100MHZ,
    input logic reset,
    adc0808_scan_ctrl_if.master bus
);

    localparam int CW = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] SETUP_LIM = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LIM = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] OE_LIM    = CW'(OE_SETTLE - 1);
    localparam logic [CW-1:0] TMO_LIM   = CW'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]  addr_q, addr_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [ADC_W-1:0] data_out_q, data_out_d;
    logic [CH_W-1:0]  data_ch_q, data_ch_d;
    logic             tmo_q, tmo_d;
    logic             ale_q, start_q, oe_q, dv_q;
    logic             eoc_m_q, eoc_s_q;
    logic             run;
`ifdef ADC_AVG4_EN
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [1:0]       nconv_q, nconv_d;
`endif

    adc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (CLK100MHZ),
        .rst_n   (reset),
        .clk_out (bus.adc_clk)
    );

    assign run = bus.scan_en && (bus.ch_mask != 8'h00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        addr_d     = addr_q;
        cur_ch_d   = cur_ch_q;
        data_out_d = data_out_q;
        data_ch_d  = data_ch_q;
        tmo_d      = tmo_q;
`ifdef ADC_AVG4_EN
        acc_d      = acc_q;
        nconv_d    = nconv_q;
        sum        = acc_q + ACC_W'(bus.data_in);
`endif
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    addr_d  = next_ch(bus.ch_mask, cur_ch_q);
                    state_d = ADDR;
                end
            end
            ADDR: if (cnt_q == SETUP_LIM) state_d = ALE;
            ALE: if (cnt_q == PULSE_LIM) state_d = START;
            START: if (cnt_q == PULSE_LIM) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!eoc_s_q) begin
                    state_d = WAIT_HI;
                end else if (cnt_q == TMO_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            WAIT_HI: begin
                if (eoc_s_q) begin
                    state_d = READ;
                end else if (cnt_q == TMO_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            READ: begin
                if (cnt_q == OE_LIM) begin
`ifdef ADC_AVG4_EN
                    if (nconv_q == 2'd3) begin
                        data_out_d = sum[ACC_W-1:2];
                        data_ch_d  = addr_q;
                        state_d    = DONE;
                    end else begin
                        acc_d   = sum;
                        nconv_d = nconv_q + 2'd1;
                        state_d = ADDR;
                    end
`else
                    data_out_d = bus.data_in;
                    data_ch_d  = addr_q;
                    state_d    = DONE;
`endif
                end
            end
            DONE: state_d = NEXT;
            NEXT: begin
                cur_ch_d = addr_q + CH_W'(1);
`ifdef ADC_AVG4_EN
                // Also discards a partial sum left behind by a timeout.
                acc_d   = '0;
                nconv_d = '0;
`endif
                if (run) begin
                    addr_d  = next_ch(bus.ch_mask, addr_q + CH_W'(1));
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            cur_ch_q   <= '0;
            data_out_q <= '0;
            data_ch_q  <= '0;
            tmo_q      <= 1'b0;
            ale_q      <= 1'b0;
            start_q    <= 1'b0;
            oe_q       <= 1'b0;
            dv_q       <= 1'b0;
            eoc_m_q    <= 1'b0;
            eoc_s_q    <= 1'b0;
`ifdef ADC_AVG4_EN
            acc_q      <= '0;
            nconv_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            cur_ch_q   <= cur_ch_d;
            data_out_q <= data_out_d;
            data_ch_q  <= data_ch_d;
            tmo_q      <= tmo_d;
            // Strobes are registered so the ADC pins never glitch.
            ale_q      <= (state_d == ALE);
            start_q    <= (state_d == START);
            oe_q       <= (state_d == READ);
            dv_q       <= (state_d == DONE);
            eoc_m_q    <= bus.eoc;
            eoc_s_q    <= eoc_m_q;
`ifdef ADC_AVG4_EN
            acc_q      <= acc_d;
            nconv_q    <= nconv_d;
`endif
        end
    end

    assign bus.ale         = ale_q;
    assign bus.start       = start_q;
    assign bus.oe          = oe_q;
    assign bus.addr        = addr_q;
    assign bus.data_out    = data_out_q;
    assign bus.data_ch     = data_ch_q;
    assign bus.data_valid  = dv_q;
    assign bus.timeout_err = tmo_q;

endmodule
